// File: rtl/bk4_seq_adder_pkg.sv
// Shared constants for the nibble-serial adder: FSM encodings and slice width.
`ifndef BK4_SEQ_ADDER_PKG_SV
`define BK4_SEQ_ADDER_PKG_SV

package bk4_seq_adder_pkg;

    localparam int NIBBLE = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Number of nibble steps for a given operand width.
    function automatic int nib_steps(input int width);
        return width / NIBBLE;
    endfunction

    // Step-counter width; a single-bit counter is kept for the degenerate case.
    function automatic int step_bits(input int width);
        int n;
        n = width / NIBBLE;
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`endif

// File: rtl/bk4.sv
// 4-bit Brent-Kung prefix adder slice with group propagate/generate outputs.
module bk4
    import bk4_seq_adder_pkg::*;
(
    input  logic [NIBBLE-1:0] x1,
    input  logic [NIBBLE-1:0] x2,
    input  logic              cin,
    output logic [NIBBLE-1:0] s,
    output logic              cout,
    output logic              p_out,
    output logic              g_out
);

    logic [3:0] p, g;
    logic       g10, p10, g32, p32, g20, p20, g30, p30;
    logic [4:0] c;

    // Prefix tree: pairs first, then the 4-wide span, then the odd fill-in node.
    always_comb begin
        p   = x1 ^ x2;
        g   = x1 & x2;
        g10 = g[1] | (p[1] & g[0]);
        p10 = p[1] & p[0];
        g32 = g[3] | (p[3] & g[2]);
        p32 = p[3] & p[2];
        g30 = g32 | (p32 & g10);
        p30 = p32 & p10;
        g20 = g[2] | (p[2] & g10);
        p20 = p[2] & p10;
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g10 | (p10 & cin);
        c[3] = g20 | (p20 & cin);
        c[4] = g30 | (p30 & cin);
        s     = p ^ c[3:0];
        cout  = c[4];
        p_out = p30;
        g_out = g30;
    end

endmodule

// File: rtl/bk4_seq_adder.sv
// Wide add/subtract built from one bk4 slice, one nibble per cycle, LSB first.
module bk4_seq_adder
    import bk4_seq_adder_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int              N      = nib_steps(WIDTH);
    localparam int              KW     = step_bits(WIDTH);
    localparam logic [KW-1:0]   LAST_K = KW'(N - 1);

    logic [1:0]        state;
    logic [KW-1:0]     k;
    logic [WIDTH-1:0]  a_reg, b_reg, sum_reg;
    logic              carry_reg, ovf_reg;

    logic [NIBBLE-1:0] x1, x2, s;
    logic              s_cout, p_unused, g_unused;
    int                nib_lo;

    // Select the current nibble of each operand for the shared slice.
    always_comb begin
        nib_lo = NIBBLE * int'(k);
        x1     = a_reg[nib_lo +: NIBBLE];
        x2     = b_reg[nib_lo +: NIBBLE];
    end

    bk4 u_slice (
        .x1    (x1),
        .x2    (x2),
        .cin   (carry_reg),
        .s     (s),
        .cout  (s_cout),
        .p_out (p_unused),
        .g_out (g_unused)
    );

    // Control FSM plus operand/result registers; the carry ripples through carry_reg.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            k         <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            carry_reg <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_reg     <= a;
                        b_reg     <= sub ? ~b : b;
                        carry_reg <= sub ? 1'b1 : cin;
                        k         <= '0;
                        sum_reg   <= '0;
                        state     <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    sum_reg[nib_lo +: NIBBLE] <= s;
                    carry_reg                 <= s_cout;
                    if (k == LAST_K) begin
                        // Top nibble: overflow when same-sign inputs yield a flipped sign.
                        ovf_reg <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                                   (s[NIBBLE-1] != a_reg[WIDTH-1]);
                        state   <= ST_DONE;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign busy      = (state != ST_IDLE);
    assign sum       = sum_reg;
    assign cout      = carry_reg;
    assign ovf       = ovf_reg;

endmodule

// File: tb/tb_bk4_seq_adder.sv
// Self-checking bench: integer reference model with cycle-count timing, plus directed literals.
module tb_bk4_seq_adder;

    localparam int W = 32;
    localparam int N = W / 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0, in_ready;
    logic [W-1:0]  a = '0, b = '0;
    logic          cin = 1'b0, sub = 1'b0;
    logic          out_valid, out_ready = 1'b0;
    logic [W-1:0]  sum;
    logic          cout, ovf, busy;

    int checks = 0;
    int errors = 0;
    logic chk_en = 1'b0;

    bk4_seq_adder #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic from plain integers: {ovf, cout, sum}.
    function automatic logic [33:0] ref_op(input logic [31:0] x, input logic [31:0] y,
                                           input logic c, input logic s);
        longint     sr;
        logic [63:0] ur;
        logic        cy, ov;
        if (s) begin
            sr = longint'($signed(x)) - longint'($signed(y));
            cy = (x >= y);
        end else begin
            sr = longint'($signed(x)) + longint'($signed(y)) + longint'(c);
            ur = {32'd0, x} + {32'd0, y} + {63'd0, c};
            cy = ur[32];
        end
        ov = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        return {ov, cy, sr[31:0]};
    endfunction

    // Model: one op in flight, result visible N edges after acceptance until consumed.
    logic        m_busy = 1'b0;
    int          m_left = 0;
    logic [33:0] m_res  = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_busy <= 1'b0;
            m_left <= 0;
        end else if (!m_busy) begin
            if (in_valid) begin
                m_res  <= ref_op(a, b, cin, sub);
                m_busy <= 1'b1;
                m_left <= N;
            end
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
        end else if (out_ready) begin
            m_busy <= 1'b0;
        end
    end

    // Compare DUT against the model on every falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready", 64'(in_ready), 64'(!m_busy));
            chk("out_valid", 64'(out_valid), 64'(m_busy && m_left == 0));
            chk("busy", 64'(busy), 64'(m_busy));
            if (m_busy && m_left == 0) begin
                chk("m_sum", 64'(sum), 64'(m_res[31:0]));
                chk("m_cout", 64'(cout), 64'(m_res[32]));
                chk("m_ovf", 64'(ovf), 64'(m_res[33]));
            end
        end
    end

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) chk("timeout", 64'(out_valid), 64'd1);
    endtask

    task automatic do_op(input string name, input logic [31:0] xa, input logic [31:0] xb,
                         input logic c, input logic s, input logic [31:0] es,
                         input logic ec, input logic eo);
        int lat;
        @(posedge clk); #1;
        a = xa; b = xb; cin = c; sub = s; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_valid(lat);
        chk({name, "_lat"}, 64'(lat), 64'(N));
        chk({name, "_sum"}, 64'(sum), 64'(es));
        chk({name, "_cout"}, 64'(cout), 64'(ec));
        chk({name, "_ovf"}, 64'(ovf), 64'(eo));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({name, "_rdy"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        logic [31:0] hs;
        logic        hc, ho;
        int          lat;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_sum", 64'(sum), 64'd0);
        chk("rst_cout", 64'(cout), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        rst = 1'b0;
        chk_en = 1'b1;

        // Directed cases with hand-computed results
        do_op("ripple", 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0);
        do_op("sub5_7", 32'd5, 32'd7, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0);
        do_op("sub7_5", 32'd7, 32'd5, 1'b0, 1'b1, 32'd2, 1'b1, 1'b0);
        do_op("ovf_add", 32'h7FFFFFFF, 32'd1, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1);
        do_op("ovf_sub", 32'h80000000, 32'd1, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1);
        do_op("cin_add", 32'd0, 32'd0, 1'b1, 1'b0, 32'd1, 1'b0, 1'b0);
        do_op("cin_sub", 32'd0, 32'd0, 1'b1, 1'b1, 32'd0, 1'b1, 1'b0);

        // Backpressure: result holds, in_ready low, in_valid pulse ignored
        @(posedge clk); #1;
        a = 32'h0F0F0F0F; b = 32'h01010101; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_valid(lat);
        hs = sum; hc = cout; ho = ovf;
        chk("bp_sum0", 64'(hs), 64'h10101010);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                in_valid = 1'b1; a = 32'hDEADBEEF; b = 32'h12345678; sub = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk); #1;
            chk("bp_sum", 64'(sum), 64'(hs));
            chk("bp_cout", 64'(cout), 64'(hc));
            chk("bp_ovf", 64'(ovf), 64'(ho));
            chk("bp_in_ready", 64'(in_ready), 64'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp_release", 64'(in_ready), 64'd1);
        do_op("after_bp", 32'h00000010, 32'h00000020, 1'b0, 1'b0, 32'h00000030, 1'b0, 1'b0);

        // Reset mid-operation at step k=3
        @(posedge clk); #1;
        a = 32'h12345678; b = 32'h11111111; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_ready", 64'(in_ready), 64'd1);
        chk("mid_rst_sum", 64'(sum), 64'd0);
        do_op("post_rst", 32'h12345678, 32'h11111111, 1'b0, 1'b0, 32'h23456789, 1'b0, 1'b0);

        // Random traffic with random backpressure and rare resets
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            in_valid  = ($urandom_range(0, 3) == 0);
            out_ready = ($urandom_range(0, 2) != 0);
            rst       = ($urandom_range(0, 299) == 0);
            case ($urandom_range(0, 5))
                0:       a = 32'h7FFFFFFF;
                1:       a = 32'h80000000;
                2:       a = 32'hFFFFFFFF;
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 4))
                0:       b = 32'h00000001;
                1:       b = 32'h80000000;
                default: b = $urandom;
            endcase
            cin = $urandom_range(0, 1);
            sub = $urandom_range(0, 1);
        end
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (N + 3) @(posedge clk);
        #1;
        chk_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
